// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle for the MEM-stage data memory controller.
// The pipeline drives the master side; the controller implements the slave side.
interface data_mem_ctrl_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  MemRead;
  logic                  MemWrite;
  logic [2:0]            Funct3;
  logic [DM_ADDRESS-1:0] a;
  logic [DATA_W-1:0]     wd;
  logic                  resp_valid;
  logic [DATA_W-1:0]     rd;
  logic                  resp_err;

  modport slave (
    input  req_valid, MemRead, MemWrite, Funct3, a, wd,
    output req_ready, resp_valid, rd, resp_err
  );

  modport master (
    output req_valid, MemRead, MemWrite, Funct3, a, wd,
    input  req_ready, resp_valid, rd, resp_err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Multi-cycle RV32I data memory: byte-lane store steering, sign/zero-extended loads,
// alignment/funct3 error reporting and WAIT_STATES extra access cycles.
module data_mem_ctrl #(
  parameter int DM_ADDRESS  = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 1
) (
  input logic             clk,
  input logic             rst_n,
  data_mem_ctrl_if.slave  bus
);
  localparam int DEPTH = 2 ** (DM_ADDRESS - 2);

  if (DATA_W != 32) begin : g_bad_width
    $error("data_mem_ctrl supports DATA_W=32 only");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [DM_ADDRESS-1:0] addr_q;
  logic [2:0]            f3_q;
  logic [31:0]           wd_q;
  logic                  wr_q;
  logic                  err_q;
  logic [31:0]           rd_q;

  logic [31:0] mem [DEPTH];

  logic accept, err_at, last_access;

  assign accept      = (state_q == IDLE) & bus.req_valid & (bus.MemRead | bus.MemWrite);
  assign last_access = (state_q == ACCESS) && (cnt_q == 3'd0);

  always_comb begin
    err_at = 1'b0;
    if (bus.MemRead & bus.MemWrite) err_at = 1'b1;
    if (bus.MemRead && (bus.Funct3 == 3'b011 || bus.Funct3[2:1] == 2'b11)) err_at = 1'b1;
    if (bus.MemWrite && bus.Funct3 > 3'b010) err_at = 1'b1;
    // Width is encoded in Funct3[1:0] for both loads and stores
    if (bus.Funct3[1:0] == 2'b01 && bus.a[0]) err_at = 1'b1;
    if (bus.Funct3[1:0] == 2'b10 && bus.a[1:0] != 2'b00) err_at = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        if (err_at) state_d = RESP;
        else begin
          state_d = ACCESS;
          cnt_d   = 3'(WAIT_STATES);
        end
      end
      ACCESS: if (cnt_q == 3'd0) state_d = RESP;
              else cnt_d = cnt_q - 3'd1;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Store lane steering
  logic [DM_ADDRESS-3:0] idx;
  logic [3:0]            be;
  logic [31:0]           wdata, word, shifted, ld_val;
  logic [15:0]           half;

  assign idx     = addr_q[DM_ADDRESS-1:2];
  assign word    = mem[idx];
  assign shifted = word >> {addr_q[1:0], 3'b000};
  assign half    = addr_q[1] ? word[31:16] : word[15:0];

  always_comb begin
    be    = 4'b1111;
    wdata = wd_q;
    case (f3_q[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_q[1:0];
        wdata = {4{wd_q[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << {addr_q[1], 1'b0};
        wdata = {2{wd_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_val = word;
    case (f3_q)
      3'b000:  ld_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  ld_val = {24'b0, shifted[7:0]};
      3'b001:  ld_val = {{16{half[15]}}, half};
      3'b101:  ld_val = {16'b0, half};
      default: ld_val = word;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      f3_q   <= 3'b0;
      wd_q   <= 32'b0;
      wr_q   <= 1'b0;
      err_q  <= 1'b0;
      rd_q   <= 32'b0;
    end else if (accept) begin
      addr_q <= bus.a;
      f3_q   <= bus.Funct3;
      wd_q   <= bus.wd;
      wr_q   <= bus.MemWrite;
      err_q  <= err_at;
      rd_q   <= 32'b0;
    end else if (last_access) begin
      rd_q <= wr_q ? 32'b0 : ld_val;
    end
  end

  // Array is not reset; an aborted op never reaches last_access so nothing commits
  always_ff @(posedge clk) begin
    if (last_access && wr_q) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.rd         = bus.resp_valid ? rd_q : 32'b0;
  assign bus.resp_err   = bus.resp_valid & err_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: drivers push expected responses, a negedge
// monitor pops and compares data, error flag and accept-to-response latency.
module tb_data_mem_ctrl;
  localparam int AW = 9;
  localparam int WS = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_ctrl_if #(.DM_ADDRESS(AW), .DATA_W(32)) bus ();

  data_mem_ctrl #(.DM_ADDRESS(AW), .DATA_W(32), .WAIT_STATES(WS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_resp = -100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor
  exp_t me;
  int   ma;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.resp_valid) begin
        last_resp = cyc;
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got resp_valid=1 expected no response (cycle %0d)", cyc);
        end else begin
          me = exp_q.pop_front();
          ma = acc_q.pop_front();
          check("rd", bus.rd, me.rd);
          check("resp_err", {31'b0, bus.resp_err}, {31'b0, me.err});
          check("latency", 32'(cyc - ma), 32'(me.lat));
          check("req_ready_in_resp", {31'b0, bus.req_ready}, 32'd0);
        end
      end else begin
        check("idle_outputs_zero", bus.rd | {31'b0, bus.resp_err}, 32'd0);
      end
    end
  end

  task automatic op(input logic rdq, input logic wrq, input logic [2:0] f3,
                    input logic [AW-1:0] addr, input logic [31:0] wdata,
                    input logic [31:0] erd, input logic eerr,
                    input bit hold, input bit b2b);
    exp_t e;
    e.rd  = erd;
    e.err = eerr;
    e.lat = eerr ? 0 : WS + 1;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.MemRead   = rdq;
    bus.MemWrite  = wrq;
    bus.Funct3    = f3;
    bus.a         = addr;
    bus.wd        = wdata;
    for (int n = 0; n < 50 && !bus.req_ready; n++) @(negedge clk);
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 within 50 cycles");
      bus.req_valid = 1'b0;
      return;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    acc_q.push_back(cyc);
    if (b2b) check("b2b_accept_cycle", 32'(cyc), 32'(last_resp + 2));
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.Funct3    = 3'b0;
    bus.a         = '0;
    bus.wd        = 32'b0;
    #2;
    check("reset_req_ready", {31'b0, bus.req_ready}, 32'd1);
    check("reset_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("reset_rd", bus.rd, 32'd0);
    check("reset_resp_err", {31'b0, bus.resp_err}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // T1
    op(0, 1, 3'b010, 9'h010, 32'hDEADBEEF, 32'h0, 0, 0, 0);
    op(1, 0, 3'b010, 9'h010, 32'h0, 32'hDEADBEEF, 0, 0, 0);
    // T2
    op(0, 1, 3'b010, 9'h010, 32'h11223344, 32'h0, 0, 0, 0);
    op(0, 1, 3'b000, 9'h013, 32'h000000A5, 32'h0, 0, 0, 0);
    op(1, 0, 3'b010, 9'h010, 32'h0, 32'hA5223344, 0, 0, 0);
    op(1, 0, 3'b000, 9'h013, 32'h0, 32'hFFFFFFA5, 0, 0, 0);
    op(1, 0, 3'b100, 9'h013, 32'h0, 32'h000000A5, 0, 0, 0);
    // T3
    op(0, 1, 3'b010, 9'h020, 32'h00000000, 32'h0, 0, 0, 0);
    op(0, 1, 3'b001, 9'h022, 32'h00008001, 32'h0, 0, 0, 0);
    op(1, 0, 3'b001, 9'h022, 32'h0, 32'hFFFF8001, 0, 0, 0);
    op(1, 0, 3'b101, 9'h022, 32'h0, 32'h00008001, 0, 0, 0);
    op(1, 0, 3'b010, 9'h020, 32'h0, 32'h80010000, 0, 0, 0);
    // T4
    op(1, 0, 3'b010, 9'h011, 32'h0, 32'h0, 1, 0, 0);
    op(0, 1, 3'b001, 9'h021, 32'h0000FFFF, 32'h0, 1, 0, 0);
    op(1, 0, 3'b010, 9'h020, 32'h0, 32'h80010000, 0, 0, 0);
    op(1, 0, 3'b011, 9'h020, 32'h0, 32'h0, 1, 0, 0);
    op(1, 1, 3'b010, 9'h020, 32'h0, 32'h0, 1, 0, 0);
    op(0, 1, 3'b100, 9'h020, 32'h0, 32'h0, 1, 0, 0);
    op(1, 0, 3'b001, 9'h023, 32'h0, 32'h0, 1, 0, 0);
    op(1, 0, 3'b010, 9'h020, 32'h0, 32'h80010000, 0, 0, 0);
    wait_drain();

    // req_valid without an op is ignored
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("ignored_req_ready", {31'b0, bus.req_ready}, 32'd1);
    end
    bus.req_valid = 1'b0;

    // T5 back-to-back with req_valid held
    op(0, 1, 3'b010, 9'h040, 32'h01020304, 32'h0, 0, 1, 0);
    op(1, 0, 3'b010, 9'h040, 32'h0, 32'h01020304, 0, 1, 1);
    op(0, 1, 3'b010, 9'h044, 32'hA0B0C0D0, 32'h0, 0, 1, 1);
    op(1, 0, 3'b010, 9'h044, 32'h0, 32'hA0B0C0D0, 0, 0, 1);
    wait_drain();

    // T6 reset during ACCESS discards the store
    op(0, 1, 3'b010, 9'h030, 32'hCAFEF00D, 32'h0, 0, 0, 0);
    op(0, 1, 3'b010, 9'h030, 32'h12345678, 32'h0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    #1;
    check("abort_req_ready", {31'b0, bus.req_ready}, 32'd1);
    check("abort_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("abort_rd", bus.rd, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_resp", {31'b0, bus.resp_valid}, 32'd0);
    end
    rst_n = 1'b1;
    op(1, 0, 3'b010, 9'h030, 32'h0, 32'hCAFEF00D, 0, 0, 0);
    wait_drain();

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
